// File: rtl/occupancy_ctrl_pkg.sv
// Shared types and helpers for the occupancy controller.
package occ_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_IN  = 2'd1,
        GATE_OUT = 2'd2
    } occ_state_t;

    // Occupancy count width; must hold 0..CAPACITY with CAPACITY <= 15.
    localparam int CNT_W = 4;

    // Width of a timer that counts 0..cycles-1 (at least one bit).
    function automatic int tmr_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/occupancy_ctrl_if.sv
// Key inputs and display/gate outputs of the occupancy controller.
interface occ_if;
    import occ_pkg::*;

    logic             key_enter_n;
    logic             key_exit_n;
    logic [CNT_W-1:0] seg_disp;
    logic             is_full;
    logic             gate_open;
    logic             reject;

    // Controller side: consumes keys, drives display and gate.
    modport slave (
        input  key_enter_n, key_exit_n,
        output seg_disp, is_full, gate_open, reject
    );

    // Environment side: drives keys, observes display and gate.
    modport master (
        output key_enter_n, key_exit_n,
        input  seg_disp, is_full, gate_open, reject
    );

endinterface

// File: rtl/occupancy_ctrl_key_debounce.sv
// Raw active-low key -> synchronized, debounced, single-cycle press pulse.
// A level is accepted once the synced key has differed from the accepted
// level for DEBOUNCE_CYCLES consecutive samples; any return resets the run.
module key_debounce
    import occ_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int             DW   = tmr_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DMAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          level;
    logic [DW-1:0] cnt;

    // Two-flop synchronizer; released (1) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Stability counter, accepted level, and pulse on an accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 1'b1;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DMAX) begin
                level     <= sync2;
                cnt       <= '0;
                press_evt <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/occupancy_ctrl.sv
// Occupancy sequencer: debounced entry/exit events, timed gate cycle,
// saturating occupancy count and FULL indication for the display stage.
// Optional feature macro: OCC_FULL_BLINK_EN (is_full blinks while full).
module occupancy_ctrl
    import occ_pkg::*;
#(
    parameter int CAPACITY        = 15,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int GATE_CYCLES     = 50_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    occ_if.slave bus
);

    localparam int               GW   = tmr_w(GATE_CYCLES);
    localparam logic [GW-1:0]    GMAX = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP  = CNT_W'(CAPACITY);

    logic             enter_evt, exit_evt;
    logic             exit_ok, enter_ok;
    occ_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [GW-1:0]    gate_tmr, gate_tmr_nxt;
    logic             reject_q, reject_nxt;
    logic             full_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (bus.key_enter_n),
        .press_evt (enter_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (bus.key_exit_n),
        .press_evt (exit_evt)
    );

    // Exit wins a tie; an enter is only taken when no exit is taken.
    assign exit_ok  = exit_evt && (count != '0);
    assign enter_ok = !exit_ok && enter_evt && (count != CAP);

    // State, count, gate timer and reject registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            gate_tmr <= '0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            gate_tmr <= gate_tmr_nxt;
            reject_q <= reject_nxt;
        end
    end

    // Next-state logic: accept/refuse in IDLE, run the gate timer otherwise.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        gate_tmr_nxt = gate_tmr;
        reject_nxt   = 1'b0;
        case (state)
            IDLE: begin
                gate_tmr_nxt = '0;
                if (exit_ok) begin
                    count_nxt = count - 1'b1;
                    state_nxt = GATE_OUT;
                end else if (enter_ok) begin
                    count_nxt = count + 1'b1;
                    state_nxt = GATE_IN;
                end else begin
                    reject_nxt = enter_evt | exit_evt;
                end
            end
            GATE_IN, GATE_OUT: begin
                // Events here are dropped silently.
                if (gate_tmr == GMAX) begin
                    state_nxt    = IDLE;
                    gate_tmr_nxt = '0;
                end else begin
                    gate_tmr_nxt = gate_tmr + 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                gate_tmr_nxt = '0;
            end
        endcase
    end

`ifdef OCC_FULL_BLINK_EN
    localparam int            BW   = tmr_w(BLINK_CYCLES);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] blink_tmr;

    // Blink while full: high on the edge the count reaches CAP, toggle every BLINK_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            blink_tmr <= '0;
        end else if (count_nxt != CAP) begin
            full_q    <= 1'b0;
            blink_tmr <= '0;
        end else if (count != CAP) begin
            full_q    <= 1'b1;
            blink_tmr <= '0;
        end else if (blink_tmr == BMAX) begin
            full_q    <= ~full_q;
            blink_tmr <= '0;
        end else begin
            blink_tmr <= blink_tmr + 1'b1;
        end
    end
`else
    // Steady full flag, updated on the same edge as the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full_q <= 1'b0;
        else        full_q <= (count_nxt == CAP);
    end
`endif

    assign bus.seg_disp  = count;
    assign bus.is_full   = full_q;
    assign bus.gate_open = (state != IDLE);
    assign bus.reject    = reject_q;

endmodule
